// File: rtl/uart_seq_pkg.sv
// rtl/uart_seq_pkg.sv - state encoding and status/address constants for the UART bus sequencer
package uart_seq_pkg;

   typedef enum logic [2:0] {
      ST_POLL   = 3'd0,
      ST_STAT   = 3'd1,
      ST_RXRD   = 3'd2,
      ST_RXCAP  = 3'd3,
      ST_TXWR   = 3'd4,
      ST_SETTLE = 3'd5
   } seq_state_e;

   localparam int         STAT_RX_BIT      = 0;
   localparam int         STAT_TX_BUSY_BIT = 1;
   localparam logic [7:0] DATA_OFFSET      = 8'h01;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-client round-robin arbiter; priority passes the granted client on advance
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic       o_grant
);

   logic r_prio;

   // Favoured client wins when requesting, otherwise the other one takes it.
   always_comb begin
      o_grant = r_prio;
      if (!i_req[r_prio]) begin
         o_grant = ~r_prio;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prio <= 1'b0;
      end else if (i_advance) begin
         r_prio <= ~o_grant;
      end
   end

endmodule

// File: rtl/uart_bus_sequencer.sv
// rtl/uart_bus_sequencer.sv - polls a byte-wide UART, drains RX into a holding register
// and writes TX bytes from two round-robin clients, with a settle gap after each write.
module uart_bus_sequencer
   import uart_seq_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR  = 8'h00,
   parameter int         SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] bus_ab,
   output logic [7:0] bus_do,
   input  logic [7:0] bus_di,
   output logic       bus_cs,
   output logic       bus_we,
   input  logic [1:0] tx_valid,
   input  logic [7:0] tx_data0,
   input  logic [7:0] tx_data1,
   output logic [1:0] tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready
);

   generate
      if (SETTLE_CYC < 2) begin : g_bad_settle
         $error("uart_bus_sequencer: SETTLE_CYC must be at least 2");
      end
      if (BASE_ADDR[0] != 1'b0) begin : g_bad_base
         $error("uart_bus_sequencer: BASE_ADDR must be even");
      end
   endgenerate

   localparam int               CNT_W    = $clog2(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [7:0]       DATA_ADDR = BASE_ADDR | DATA_OFFSET;

   seq_state_e       r_state;
   seq_state_e       w_next;
   logic [CNT_W-1:0] r_settle_cnt;
   logic             r_grant;
   logic             r_rx_valid;
   logic [7:0]       r_rx_data;
   logic             w_arb_grant;
   logic             w_take_rx;
   logic             w_take_tx;

   // RX wins over TX; a held byte blocks further reads until consumed.
   assign w_take_rx = (r_state == ST_STAT) && bus_di[STAT_RX_BIT] && !r_rx_valid;
   assign w_take_tx = (r_state == ST_STAT) && !w_take_rx && !bus_di[STAT_TX_BUSY_BIT] && (|tx_valid);

   rr_arb2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .i_req     (tx_valid),
      .i_advance (w_take_tx),
      .o_grant   (w_arb_grant)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_POLL:   w_next = ST_STAT;
         ST_STAT:   w_next = w_take_rx ? ST_RXRD : (w_take_tx ? ST_TXWR : ST_POLL);
         ST_RXRD:   w_next = ST_RXCAP;
         ST_RXCAP:  w_next = ST_POLL;
         ST_TXWR:   w_next = ST_SETTLE;
         ST_SETTLE: if (r_settle_cnt == CNT_LAST) w_next = ST_POLL;
         default:   w_next = ST_POLL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_POLL;
         r_settle_cnt <= '0;
         r_grant      <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_data    <= 8'h00;
      end else begin
         r_state <= w_next;
         if (r_state == ST_SETTLE) begin
            r_settle_cnt <= (r_settle_cnt == CNT_LAST) ? '0 : r_settle_cnt + 1'b1;
         end
         if (w_take_tx) begin
            r_grant <= w_arb_grant;
         end
         if (r_state == ST_RXCAP) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= bus_di;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   // Strobes are decoded from state and masked while reset is held.
   always_comb begin
      bus_cs   = 1'b0;
      bus_we   = 1'b0;
      bus_ab   = BASE_ADDR;
      bus_do   = 8'h00;
      tx_ready = 2'b00;
      if (!reset) begin
         case (r_state)
            ST_POLL: bus_cs = 1'b1;
            ST_RXRD: begin
               bus_cs = 1'b1;
               bus_ab = DATA_ADDR;
            end
            ST_TXWR: begin
               bus_cs   = 1'b1;
               bus_we   = 1'b1;
               bus_ab   = DATA_ADDR;
               bus_do   = r_grant ? tx_data1 : tx_data0;
               tx_ready = r_grant ? 2'b10 : 2'b01;
            end
            default: ;
         endcase
      end
   end

   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// tb/tb_uart_bus_sequencer.sv - self-checking bench for uart_bus_sequencer
module tb_uart_bus_sequencer;

   localparam int K_POLL = 0;
   localparam int K_STAT = 1;
   localparam int K_RD   = 2;
   localparam int K_CAP  = 3;
   localparam int K_WR   = 4;
   localparam int K_IDLE = 5;

   logic       clk;
   logic       reset;
   logic [1:0] tx_valid;
   logic [7:0] tx_data0;
   logic [7:0] tx_data1;
   logic       rx_ready;
   logic [7:0] bus_di   [2];
   logic [7:0] bus_ab   [2];
   logic [7:0] bus_do   [2];
   logic       bus_cs   [2];
   logic       bus_we   [2];
   logic [1:0] tx_ready [2];
   logic [7:0] rx_data  [2];
   logic       rx_valid [2];

   logic [7:0] uart_status;
   logic [7:0] uart_data;
   logic [7:0] stat_ret [2];
   logic [7:0] data_ret [2];
   logic       rd_seen  [2];
   logic       rd_dat   [2];

   int         n_checks;
   int         n_fail;

   int         plan [2][16];
   int         plen [2];
   int         ppos [2];
   logic       m_rxv  [2];
   logic [7:0] m_rxd  [2];
   logic       m_pref [2];
   logic       m_g    [2];

   int         rel;
   int         first_rd_cyc  [2];
   logic [7:0] first_rd_ab   [2];
   int         first_rxv_cyc [2];
   logic [7:0] first_rxd     [2];
   int         data_rd_cnt   [2];
   int         wr_cnt        [2];
   int         last_wr       [2];
   int         last_gap      [2];
   logic       wr_pend       [2];
   logic [7:0] wr_log0 [$];

   uart_bus_sequencer #(.BASE_ADDR(8'h00), .SETTLE_CYC(2)) dut0 (
      .clk(clk), .reset(reset),
      .bus_ab(bus_ab[0]), .bus_do(bus_do[0]), .bus_di(bus_di[0]),
      .bus_cs(bus_cs[0]), .bus_we(bus_we[0]),
      .tx_valid(tx_valid), .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_ready(tx_ready[0]),
      .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready)
   );

   uart_bus_sequencer #(.BASE_ADDR(8'h40), .SETTLE_CYC(5)) dut1 (
      .clk(clk), .reset(reset),
      .bus_ab(bus_ab[1]), .bus_do(bus_do[1]), .bus_di(bus_di[1]),
      .bus_cs(bus_cs[1]), .bus_we(bus_we[1]),
      .tx_valid(tx_valid), .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_ready(tx_ready[1]),
      .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_plan(input int k, input int kind);
      plan[k][plen[k]] = kind;
      plen[k]++;
   endtask

   // UART register model: answers a read strobe on the following cycle.
   initial begin
      for (int k = 0; k < 2; k++) begin
         bus_di[k]   = 8'hEE;
         stat_ret[k] = 8'h00;
         data_ret[k] = 8'h00;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            rd_seen[k] = bus_cs[k] && !bus_we[k];
            rd_dat[k]  = bus_ab[k][0];
         end
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (rd_seen[k] && rd_dat[k]) begin
               bus_di[k]   = uart_data;
               data_ret[k] = uart_data;
            end else if (rd_seen[k]) begin
               bus_di[k]   = uart_status;
               stat_ret[k] = uart_status;
            end else begin
               bus_di[k] = 8'hEE;
            end
         end
      end
   end

   // Transaction-level model: each poll expands into a script of bus cycles.
   task automatic model_cycle(input int k);
      logic       e_cs;
      logic       e_we;
      logic [7:0] e_ab;
      logic [7:0] e_do;
      logic [1:0] e_txr;
      logic [7:0] base;
      logic       g;
      int         kind;
      base  = (k == 1) ? 8'h40 : 8'h00;
      e_cs  = 1'b0;
      e_we  = 1'b0;
      e_ab  = base;
      e_do  = 8'h00;
      e_txr = 2'b00;
      kind  = -1;
      if (!reset) begin
         if (ppos[k] == plen[k]) begin
            plen[k] = 0;
            ppos[k] = 0;
            push_plan(k, K_POLL);
            push_plan(k, K_STAT);
         end
         kind = plan[k][ppos[k]];
         ppos[k]++;
         case (kind)
            K_POLL: e_cs = 1'b1;
            K_STAT: begin
               if (stat_ret[k][0] && !m_rxv[k]) begin
                  push_plan(k, K_RD);
                  push_plan(k, K_CAP);
               end else if (!stat_ret[k][1] && (tx_valid != 2'b00)) begin
                  g = (tx_valid == 2'b11) ? m_pref[k] : tx_valid[1];
                  m_g[k]    = g;
                  m_pref[k] = ~g;
                  push_plan(k, K_WR);
                  for (int i = 0; i < ((k == 1) ? 5 : 2); i++) push_plan(k, K_IDLE);
               end
            end
            K_RD: begin
               e_cs = 1'b1;
               e_ab = base + 8'h01;
            end
            K_WR: begin
               e_cs  = 1'b1;
               e_we  = 1'b1;
               e_ab  = base + 8'h01;
               e_do  = m_g[k] ? tx_data1 : tx_data0;
               e_txr = m_g[k] ? 2'b10 : 2'b01;
            end
            default: ;
         endcase
      end
      chk($sformatf("dut%0d bus_cs", k), 32'(bus_cs[k]), 32'(e_cs));
      chk($sformatf("dut%0d bus_we", k), 32'(bus_we[k]), 32'(e_we));
      chk($sformatf("dut%0d bus_ab", k), 32'(bus_ab[k]), 32'(e_ab));
      chk($sformatf("dut%0d bus_do", k), 32'(bus_do[k]), 32'(e_do));
      chk($sformatf("dut%0d tx_ready", k), 32'(tx_ready[k]), 32'(e_txr));
      chk($sformatf("dut%0d rx_valid", k), 32'(rx_valid[k]), 32'(m_rxv[k]));
      chk($sformatf("dut%0d rx_data", k), 32'(rx_data[k]), 32'(m_rxd[k]));
      if (!reset) begin
         if (bus_cs[k] && !bus_we[k] && bus_ab[k][0]) begin
            data_rd_cnt[k]++;
            if (first_rd_cyc[k] < 0) begin
               first_rd_cyc[k] = rel;
               first_rd_ab[k]  = bus_ab[k];
            end
         end
         if (rx_valid[k] && first_rxv_cyc[k] < 0) begin
            first_rxv_cyc[k] = rel;
            first_rxd[k]     = rx_data[k];
         end
         if (bus_cs[k] && bus_we[k]) begin
            wr_cnt[k]++;
            if (k == 0) wr_log0.push_back(bus_do[k]);
            last_wr[k] = rel;
            wr_pend[k] = 1'b1;
         end
         if (bus_cs[k] && !bus_we[k] && !bus_ab[k][0] && wr_pend[k]) begin
            last_gap[k] = rel - last_wr[k];
            wr_pend[k]  = 1'b0;
         end
      end
      if (reset) begin
         m_rxv[k]  = 1'b0;
         m_rxd[k]  = 8'h00;
         m_pref[k] = 1'b0;
         plen[k]   = 0;
         ppos[k]   = 0;
      end else begin
         if (m_rxv[k] && rx_ready) m_rxv[k] = 1'b0;
         if (kind == K_CAP) begin
            m_rxv[k] = 1'b1;
            m_rxd[k] = data_ret[k];
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rel      = 0;
      for (int k = 0; k < 2; k++) begin
         plen[k] = 0;  ppos[k] = 0;  m_rxv[k] = 1'b0;  m_rxd[k] = 8'h00;
         m_pref[k] = 1'b0;  m_g[k] = 1'b0;
         first_rd_cyc[k] = -1;  first_rxv_cyc[k] = -1;  first_rd_ab[k] = 8'h00;
         first_rxd[k] = 8'h00;  data_rd_cnt[k] = 0;  wr_cnt[k] = 0;
         last_wr[k] = 0;  last_gap[k] = -1;  wr_pend[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) model_cycle(k);
         rel = reset ? 0 : rel + 1;
      end
   end

   initial begin
      int   snap_rd0, snap_rd1, snap_wr0, snap_wr1;
      logic found;
      int   exp_b [3];
      exp_b = '{32'h11, 32'h22, 32'h11};

      reset       = 1'b1;
      uart_status = 8'h01;
      uart_data   = 8'hA5;
      rx_ready    = 1'b1;
      tx_valid    = 2'b00;
      tx_data0    = 8'h11;
      tx_data1    = 8'h22;
      step(3);
      reset = 1'b0;
      step(12);
      chk("A data addr dut0", 32'(first_rd_ab[0]), 32'h01);
      chk("A data addr dut1", 32'(first_rd_ab[1]), 32'h41);
      chk("A RXRD cycle", first_rd_cyc[0], 2);
      chk("A rx_valid latency", first_rxv_cyc[0], 4);
      chk("A rx_data", 32'(first_rxd[0]), 32'hA5);

      uart_status = 8'h00;
      tx_valid    = 2'b11;
      wr_log0.delete();
      step(40);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("B write %0d", i), (i < wr_log0.size()) ? 32'(wr_log0[i]) : 32'hDEAD, exp_b[i]);
      end

      uart_status = 8'h02;
      tx_valid    = 2'b01;
      step(10);
      snap_wr0 = wr_cnt[0];
      snap_wr1 = wr_cnt[1];
      step(30);
      chk("C busy no write dut0", wr_cnt[0] - snap_wr0, 0);
      chk("C busy no write dut1", wr_cnt[1] - snap_wr1, 0);
      uart_status = 8'h00;
      step(15);
      chk("C write resumes", 32'(wr_cnt[0] > snap_wr0), 1);

      last_gap[0] = -1;
      last_gap[1] = -1;
      step(25);
      chk("E settle gap 2", last_gap[0], 3);
      chk("E settle gap 5", last_gap[1], 6);

      uart_status = 8'h03;
      rx_ready    = 1'b0;
      step(15);
      chk("D rx held", 32'(rx_valid[0]), 1);
      snap_rd0 = data_rd_cnt[0];
      snap_rd1 = data_rd_cnt[1];
      snap_wr0 = wr_cnt[0];
      step(25);
      chk("D no RXRD while held", data_rd_cnt[0] - snap_rd0, 0);
      chk("D no TX while busy", wr_cnt[0] - snap_wr0, 0);
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
      step(15);
      chk("D RXRD after consume dut0", data_rd_cnt[0] - snap_rd0, 1);
      chk("D RXRD after consume dut1", data_rd_cnt[1] - snap_rd1, 1);

      tx_valid    = 2'b00;
      uart_status = 8'h01;
      uart_data   = 8'h5A;
      rx_ready    = 1'b1;
      found       = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1);
         if (bus_cs[0] && !bus_we[0] && bus_ab[0] == 8'h01) found = 1'b1;
      end
      chk("F reached RXRD", 32'(found), 1);
      reset = 1'b1;
      step(1);
      @(negedge clk);
      #1;
      chk("F reset bus_cs", 32'(bus_cs[0]), 0);
      chk("F reset bus_ab", 32'(bus_ab[0]), 32'h00);
      chk("F reset tx_ready", 32'(tx_ready[0]), 0);
      chk("F reset rx_valid", 32'(rx_valid[0]), 0);
      chk("F reset rx_data", 32'(rx_data[0]), 0);
      step(1);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("F first poll cs", 32'(bus_cs[0]), 1);
      chk("F first poll we", 32'(bus_we[0]), 0);
      chk("F first poll ab dut1", 32'(bus_ab[1]), 32'h40);
      step(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_bus_sequencer.md
UART_BUS_SEQUENCER -- requirements
Module: uart_bus_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00, UART status register address; BASE_ADDR[0] SHALL be 0; data register is BASE_ADDR|1.
REQ-002 Parameter SETTLE_CYC, default 2, idle cycles after a UART write before the next poll; values below 2 SHALL be rejected at elaboration.
REQ-003 clk  in  1  clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 bus_ab  out  8  UART address bus.
REQ-006 bus_do  out  8  write data to the UART.
REQ-007 bus_di  in  8  read data from the UART, valid the cycle after a read strobe.
REQ-008 bus_cs  out  1  UART chip select, one-cycle strobe.
REQ-009 bus_we  out  1  write qualifier for bus_cs.
REQ-010 tx_valid  in  2  per-client byte-pending; held with data until tx_ready.
REQ-011 tx_data0, tx_data1  in  8 each  client bytes.
REQ-012 tx_ready  out  2  per-client accept pulse.
REQ-013 rx_data  out  8  received byte.
REQ-014 rx_valid  out  1  rx_data holds an unconsumed byte.
REQ-015 rx_ready  in  1  sink consumes on rx_valid&&rx_ready.

Function
REQ-016 FSM states: POLL, STAT, RXRD, RXCAP, TXWR, SETTLE.
REQ-017 POLL: bus_cs=1, bus_we=0, bus_ab=BASE_ADDR; next STAT.
REQ-018 STAT: sample bus_di; bit0=rx_avail, bit1=tx_busy; bits 7:2 ignored.
REQ-019 STAT: if rx_avail and !rx_valid -> RXRD; else if !tx_busy and |tx_valid -> TXWR; else -> POLL. RX has priority over TX.
REQ-020 RXRD: bus_cs=1, bus_we=0, bus_ab=BASE_ADDR|1; next RXCAP.
REQ-021 RXCAP: rx_data<=bus_di, rx_valid<=1 at cycle end; next POLL.
REQ-022 rx_valid SHALL clear on the cycle after rx_valid&&rx_ready; while rx_valid=1 no RXRD is issued; UART-side overrun is not detected.
REQ-023 TX arbitration: round-robin over clients 0/1; grant registered on STAT->TXWR; pointer moves past the granted client after each grant; only one client requesting -> that client.
REQ-024 TXWR: bus_cs=1, bus_we=1, bus_ab=BASE_ADDR|1, bus_do=granted client's data, tx_ready[grant]=1 for this cycle only; next SETTLE.
REQ-025 SETTLE: bus_cs=0 for SETTLE_CYC cycles, then POLL; guarantees the next status read reflects tx_busy=1.
REQ-026 Outside POLL/RXRD/TXWR: bus_cs=0, bus_we=0, bus_ab=BASE_ADDR, bus_do=0; tx_ready=0 outside TXWR.
REQ-027 Latency: status poll 2 cycles; RX byte to rx_valid 4 cycles from POLL; TX accept 3 cycles from POLL.
REQ-028 tx_valid dropping before TXWR (protocol violation): TXWR still writes and pulses; no recovery.

Reset
REQ-029 On reset: state=POLL, rx_valid=0, rx_data=0, tx_ready=0, bus_cs=0, bus_we=0, bus_ab=BASE_ADDR, bus_do=0, round-robin favours client 0, settle counter=0.
REQ-030 Reset mid-transaction aborts immediately; a byte in RXCAP is discarded; a pending tx_ready is not issued.
REQ-031 First bus strobe after reset release SHALL be a POLL read on the first clock.

Structure
REQ-032 Package uart_seq_pkg: FSM state enum, STAT_RX_BIT=0, STAT_TX_BUSY_BIT=1, DATA_OFFSET=1.
REQ-033 Sub-module rr_arb2: 2-way round-robin arbiter with advance input.
REQ-034 Top level: FSM, settle counter, RX holding register.

Verification
REQ-035 UART model returns status 8'h01, data 8'hA5, rx_ready=1 -> RXRD at addr 8'h01, rx_valid=1 with rx_data=8'hA5, 4 cycles after POLL.
REQ-036 Status 8'h00, tx_valid=2'b11, data0=8'h11, data1=8'h22 -> writes 8'h11, then 8'h22, then 8'h11 alternately; each tx_ready one cycle.
REQ-037 Status 8'h02 (busy) with tx_valid=2'b01 -> POLL/STAT loop only, no write, tx_ready=0 until status 8'h00.
REQ-038 Status 8'h03, rx_valid already 1, rx_ready=0 -> no RXRD; TX not issued while tx_busy=1; after rx_ready pulse, next poll issues RXRD.
REQ-039 Status 8'h00, tx_valid=2'b01 -> TXWR, then exactly SETTLE_CYC idle cycles before POLL (check SETTLE_CYC=2 and 5).
REQ-040 reset asserted during RXRD -> next cycle all outputs at reset values, rx_valid=0, POLL on first cycle after release.
